lsm_stimulus_sequencer: RTL and testbench
=========================================

# lsm_stimulus_sequencer

Drives the stimulus side of the LSM reservoir interface and captures its readout.
- Replays a loaded 16-input spike pattern and 8-bit external excitation as timestep pulses.
- Steps the reservoir through its three operating phases, generating write and the ST/CT teacher/control lines for each.
- During the final phase, counts output_reg1/output_reg2 activity so a host can read a classification score.
- Sits between the host/config logic and LSM_reservoir, replacing bench-driven stimulus in synthesized builds.

## Interface
- SPIKE_NEURONS, 15: spikes_in is SPIKE_NEURONS+1 bits wide.
- EXTERNAL_EIN, 7: Ein_ext is EXTERNAL_EIN+1 bits wide.
- STEP_CYCLES, 10: clocks per timestep; must be ≥2.
- PHASE_A_STEPS, 16: timesteps in phase A (settle); must be ≥1.
- PHASE_B_STEPS, 64: timesteps in phase B (train); must be ≥1.
- PHASE_C_STEPS, 32: timesteps in phase C (readout); must be ≥1.
- clock, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-low; clears all state.
- load_valid, in, 1: pattern load request.
- load_ready, out, 1: high in IDLE and DONE only.
- pattern_in, in, SPIKE_NEURONS+1: spike pattern to load.
- ein_in, in, EXTERNAL_EIN+1: excitation word to load.
- start, in, 1: begin a run; sampled only in IDLE/DONE.
- busy, out, 1: high in phases A, B and C.
- done, out, 1: high in DONE.
- phase, out, 2: 0=IDLE, 1=A, 2=B, 3=C; DONE reports 0.
- step_strobe, out, 1: high on cycle 0 of each timestep.
- spikes_in, out, SPIKE_NEURONS+1: to reservoir.
- Ein_ext, out, EXTERNAL_EIN+1: to reservoir.
- write, ST_and, CT_and, ST1, ST2, CT1, CT2: out, 1 each; to reservoir.
- output_reg1, output_reg2: in, 1 each; from reservoir.
- count1, count2: out, 16 each; readout counts.

## Operation
- States: IDLE, A, B, C, DONE. Reset enters IDLE.
- **Load:** a transfer occurs on any cycle where load_valid && load_ready. It captures pattern_in/ein_in into shadow registers. Loads are ignored while busy.
- **Start:**
  - start in IDLE or DONE moves to A.
  - On the same edge: clear count1/count2, step counter and cycle counter; copy the shadow into the active pattern and ein.
  - If load and start occur on the same edge, the newly loaded values are used.
- **Timestep:** cycle counter runs 0..STEP_CYCLES-1, then wraps and increments the step counter.
  - spikes_in = active pattern when cycle counter = 0, else 0 (one-cycle pulse per step).
  - Ein_ext = active ein, held for all of A/B/C.
- **Phase transitions:** taken at the wrap of the last step of a phase (PHASE_x_STEPS steps each). The step counter resets to 0 on each transition. C → DONE.
- **Control values by state:**
  - IDLE/DONE: write=0, all ST/CT=0.
  - A: write=1, ST_and=0, CT_and=1, ST1=1, ST2=0, CT1=1, CT2=1.
  - B: write=1, ST_and=1, CT_and=0, ST1=1, ST2=1, CT1=1, CT2=0.
  - C: write=0; ST/CT as in B.
- **Readout:** in C only, count1 increments every cycle output_reg1 is sampled high; likewise count2 for output_reg2.
  - Both counters saturate at 16'hFFFF.
  - Both hold their values in DONE until the next start.
- start while busy is ignored. A new start from DONE reruns from A.

## Timing
- All outputs are registered, except load_ready (decoded from state).
- Reset values: spikes_in=0, Ein_ext=0, write=0, all ST/CT=0, busy=0, done=0, phase=0, step_strobe=0, count1=0, count2=0, load_ready=1.
- Start latency: start sampled at edge k gives, after edge k: phase=1, busy=1, write=1, step_strobe=1, spikes_in=pattern.
- Run length: (PHASE_A_STEPS+PHASE_B_STEPS+PHASE_C_STEPS)×STEP_CYCLES cycles from edge k. done rises on the following edge, while busy and write fall.
- Phase boundary: control lines change on the same edge as the first spikes_in pulse of the new phase.
- Readout window: a sample at the last cycle of C is counted. A sample on the edge that enters C is not counted.
- Reset mid-run: all outputs return to their reset values immediately. Shadow registers are cleared to 0. No partial counts survive.

## Test plan
Parameters for all scenarios: STEP_CYCLES=4, A=2, B=3, C=2.
- **Reset:** deassert reset; all outputs at reset values, load_ready=1.
- **Nominal run:**
  - Stimulus: load pattern 16'hBC32, ein 8'hFF; start.
  - spikes_in=16'hBC32 on cycles 0, 4, 8 … 24 after start, 0 otherwise.
  - phase goes 1 for 8 cycles, 2 for 12, 3 for 8; then done=1.
  - write is 1 for 20 cycles.
- **Control lines:** in A, {ST_and,CT_and,ST1,ST2,CT1,CT2} = 6'b011011. In B and C = 6'b101110. All 0 in DONE.
- **Readout saturation and hold:**
  - Drive output_reg1=1 throughout and output_reg2 high on 3 cycles of C → count1=8, count2=3 at done.
  - Force output_reg1 high before C → not counted.
  - Repeat with preset counts near FFFF → counts saturate at FFFF.
- **Handshake edges:**
  - load_valid while busy → ignored, load_ready=0.
  - start while busy → no restart.
  - load+start on the same edge → the new pattern is used.
  - start from DONE → counts cleared, run repeats.
- **Async reset mid-B:** assert reset at a non-edge time → outputs clear immediately; a subsequent start with no load plays pattern 0.

Source files
------------

// File: rtl/lsm_stimulus_sequencer.sv
// Stimulus sequencer for the LSM reservoir: replays a loaded spike/excitation pattern
// through the settle, train and readout phases and counts reservoir output activity.
module lsm_stimulus_sequencer #(
  parameter int SPIKE_NEURONS = 15,
  parameter int EXTERNAL_EIN  = 7,
  parameter int STEP_CYCLES   = 10,
  parameter int PHASE_A_STEPS = 16,
  parameter int PHASE_B_STEPS = 64,
  parameter int PHASE_C_STEPS = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [SPIKE_NEURONS:0]  pattern_in,
  input  logic [EXTERNAL_EIN:0]   ein_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              phase,
  output logic                    step_strobe,
  output logic [SPIKE_NEURONS:0]  spikes_in,
  output logic [EXTERNAL_EIN:0]   Ein_ext,
  output logic                    write,
  output logic                    ST_and,
  output logic                    CT_and,
  output logic                    ST1,
  output logic                    ST2,
  output logic                    CT1,
  output logic                    CT2,
  input  logic                    output_reg1,
  input  logic                    output_reg2,
  output logic [15:0]             count1,
  output logic [15:0]             count2
);

  localparam int CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int MAX_AB    = (PHASE_A_STEPS > PHASE_B_STEPS) ? PHASE_A_STEPS : PHASE_B_STEPS;
  localparam int MAX_STEPS = (MAX_AB > PHASE_C_STEPS) ? MAX_AB : PHASE_C_STEPS;
  localparam int SW        = $clog2(MAX_STEPS + 1);

  localparam logic [CW-1:0] LAST_CYC    = CW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STEP_A = SW'(PHASE_A_STEPS - 1);
  localparam logic [SW-1:0] LAST_STEP_B = SW'(PHASE_B_STEPS - 1);
  localparam logic [SW-1:0] LAST_STEP_C = SW'(PHASE_C_STEPS - 1);

  // Control word order: {write, ST_and, CT_and, ST1, ST2, CT1, CT2}
  localparam logic [6:0] CTRL_A = 7'b1011011;
  localparam logic [6:0] CTRL_B = 7'b1101110;
  localparam logic [6:0] CTRL_C = 7'b0101110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A,
    S_B,
    S_C,
    S_DONE
  } state_e;

  state_e                  state_q, state_d, nextPhase;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [SW-1:0]           step_q, step_d, lastStep;
  logic [SPIKE_NEURONS:0]  shadowPattern_q, shadowPattern_d;
  logic [EXTERNAL_EIN:0]   shadowEin_q, shadowEin_d;
  logic [SPIKE_NEURONS:0]  activePattern_q, activePattern_d;
  logic [EXTERNAL_EIN:0]   activeEin_q, activeEin_d;
  logic [15:0]             count1_q, count1_d;
  logic [15:0]             count2_q, count2_d;
  logic [SPIKE_NEURONS:0]  spikes_q, spikes_d;
  logic [EXTERNAL_EIN:0]   einOut_q, einOut_d;
  logic [6:0]              ctrl_q, ctrl_d;
  logic [1:0]              phase_q, phase_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    strobe_q, strobe_d;
  logic                    loadFire;

  assign load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign loadFire   = load_valid && load_ready;

  always_comb begin
    lastStep  = LAST_STEP_A;
    nextPhase = S_B;
    unique case (state_q)
      S_B: begin
        lastStep  = LAST_STEP_B;
        nextPhase = S_C;
      end
      S_C: begin
        lastStep  = LAST_STEP_C;
        nextPhase = S_DONE;
      end
      default: ;
    endcase
  end

  // Sequencing and readout; a same-edge load bypasses the shadow into the active copy.
  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    step_d          = step_q;
    shadowPattern_d = shadowPattern_q;
    shadowEin_d     = shadowEin_q;
    activePattern_d = activePattern_q;
    activeEin_d     = activeEin_q;
    count1_d        = count1_q;
    count2_d        = count2_q;

    if (loadFire) begin
      shadowPattern_d = pattern_in;
      shadowEin_d     = ein_in;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = S_A;
          cyc_d           = '0;
          step_d          = '0;
          activePattern_d = loadFire ? pattern_in : shadowPattern_q;
          activeEin_d     = loadFire ? ein_in : shadowEin_q;
          count1_d        = '0;
          count2_d        = '0;
        end
      end
      default: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (step_q == lastStep) begin
            step_d  = '0;
            state_d = nextPhase;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
        if (state_q == S_C) begin
          if (output_reg1 && (count1_q != 16'hFFFF)) count1_d = count1_q + 16'd1;
          if (output_reg2 && (count2_q != 16'hFFFF)) count2_d = count2_q + 16'd1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    spikes_d = '0;
    einOut_d = '0;
    ctrl_d   = '0;
    phase_d  = 2'd0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    strobe_d = 1'b0;
    unique case (state_d)
      S_A: begin
        phase_d = 2'd1;
        busy_d  = 1'b1;
        ctrl_d  = CTRL_A;
      end
      S_B: begin
        phase_d = 2'd2;
        busy_d  = 1'b1;
        ctrl_d  = CTRL_B;
      end
      S_C: begin
        phase_d = 2'd3;
        busy_d  = 1'b1;
        ctrl_d  = CTRL_C;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
    if (busy_d) begin
      einOut_d = activeEin_d;
      if (cyc_d == '0) begin
        strobe_d = 1'b1;
        spikes_d = activePattern_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cyc_q           <= '0;
      step_q          <= '0;
      shadowPattern_q <= '0;
      shadowEin_q     <= '0;
      activePattern_q <= '0;
      activeEin_q     <= '0;
      count1_q        <= '0;
      count2_q        <= '0;
      spikes_q        <= '0;
      einOut_q        <= '0;
      ctrl_q          <= '0;
      phase_q         <= 2'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      strobe_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      step_q          <= step_d;
      shadowPattern_q <= shadowPattern_d;
      shadowEin_q     <= shadowEin_d;
      activePattern_q <= activePattern_d;
      activeEin_q     <= activeEin_d;
      count1_q        <= count1_d;
      count2_q        <= count2_d;
      spikes_q        <= spikes_d;
      einOut_q        <= einOut_d;
      ctrl_q          <= ctrl_d;
      phase_q         <= phase_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      strobe_q        <= strobe_d;
    end
  end

  assign spikes_in   = spikes_q;
  assign Ein_ext     = einOut_q;
  assign {write, ST_and, CT_and, ST1, ST2, CT1, CT2} = ctrl_q;
  assign phase       = phase_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_strobe = strobe_q;
  assign count1      = count1_q;
  assign count2      = count2_q;

endmodule

// File: tb/tb_lsm_stimulus_sequencer.sv
// Directed bench for lsm_stimulus_sequencer with STEP_CYCLES=4 and phases of 2/3/2 steps.
module tb_lsm_stimulus_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] pattern_in;
  logic [7:0]  ein_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  phase;
  logic        step_strobe;
  logic [15:0] spikes_in;
  logic [7:0]  Ein_ext;
  logic        write, ST_and, CT_and, ST1, ST2, CT1, CT2;
  logic        output_reg1;
  logic        output_reg2;
  logic [15:0] count1;
  logic [15:0] count2;
  logic [6:0]  ctrlBus;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign ctrlBus = {write, ST_and, CT_and, ST1, ST2, CT1, CT2};

  lsm_stimulus_sequencer #(
    .SPIKE_NEURONS(15),
    .EXTERNAL_EIN (7),
    .STEP_CYCLES  (4),
    .PHASE_A_STEPS(2),
    .PHASE_B_STEPS(3),
    .PHASE_C_STEPS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern_in (pattern_in),
    .ein_in     (ein_in),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .step_strobe(step_strobe),
    .spikes_in  (spikes_in),
    .Ein_ext    (Ein_ext),
    .write      (write),
    .ST_and     (ST_and),
    .CT_and     (CT_and),
    .ST1        (ST1),
    .ST2        (ST2),
    .CT1        (CT1),
    .CT2        (CT2),
    .output_reg1(output_reg1),
    .output_reg2(output_reg2),
    .count1     (count1),
    .count2     (count2)
  );

  // One comparison: counts it and reports tag/observed/expected when it misses.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives all inputs for the next rising edge, then returns just after that edge.
  task automatic applyStimulus(input logic lv, input logic [15:0] pat, input logic [7:0] ein,
                               input logic st, input logic r1, input logic r2);
    load_valid  = lv;
    pattern_in  = pat;
    ein_in      = ein;
    start       = st;
    output_reg1 = r1;
    output_reg2 = r2;
    @(posedge clock);
    #1;
  endtask

  // Directed sequence: reset, nominal run, rerun with handshake corners and saturation, reset mid-B.
  initial begin
    logic [1:0]  expPhase;
    logic [6:0]  expCtrl;

    reset       = 1'b0;
    load_valid  = 1'b0;
    pattern_in  = '0;
    ein_in      = '0;
    start       = 1'b0;
    output_reg1 = 1'b0;
    output_reg2 = 1'b0;
    #12;
    reset = 1'b1;

    checkOutput("rst_spikes", 32'(spikes_in), 32'h0);
    checkOutput("rst_ein", 32'(Ein_ext), 32'h0);
    checkOutput("rst_ctrl", 32'(ctrlBus), 32'h0);
    checkOutput("rst_status", 32'({busy, done, phase, step_strobe}), 32'h0);
    checkOutput("rst_count1", 32'(count1), 32'h0);
    checkOutput("rst_count2", 32'(count2), 32'h0);
    checkOutput("rst_load_ready", 32'(load_ready), 32'h1);

    @(posedge clock);
    #1;
    checkOutput("idle_phase", 32'(phase), 32'h0);

    applyStimulus(1'b1, 16'hBC32, 8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 28; i++) begin
      expPhase = (i < 8) ? 2'd1 : ((i < 20) ? 2'd2 : 2'd3);
      expCtrl  = (expPhase == 2'd1) ? 7'b1011011 : ((expPhase == 2'd2) ? 7'b1101110 : 7'b0101110);
      checkOutput($sformatf("nom_phase_%0d", i), 32'(phase), 32'(expPhase));
      checkOutput($sformatf("nom_spikes_%0d", i), 32'(spikes_in), (i % 4 == 0) ? 32'hBC32 : 32'h0);
      checkOutput($sformatf("nom_strobe_%0d", i), 32'(step_strobe), (i % 4 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("nom_ctrl_%0d", i), 32'(ctrlBus), 32'(expCtrl));
      checkOutput($sformatf("nom_busy_%0d", i), 32'({busy, done, load_ready}), 32'h4);
      checkOutput($sformatf("nom_ein_%0d", i), 32'(Ein_ext), 32'hFF);
      applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, (i == 19) || (i == 20) || (i == 23) || (i == 27));
    end

    checkOutput("done_status", 32'({busy, done, phase, step_strobe}), 32'h8);
    checkOutput("done_ctrl", 32'(ctrlBus), 32'h0);
    checkOutput("done_spikes", 32'(spikes_in), 32'h0);
    checkOutput("done_count1", 32'(count1), 32'd8);
    checkOutput("done_count2", 32'(count2), 32'd3);
    checkOutput("done_load_ready", 32'(load_ready), 32'h1);

    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("hold_count1", 32'(count1), 32'd8);
    checkOutput("hold_count2", 32'(count2), 32'd3);
    checkOutput("hold_done", 32'(done), 32'h1);

    applyStimulus(1'b1, 16'h1234, 8'h5A, 1'b1, 1'b0, 1'b0);
    checkOutput("rerun_phase", 32'(phase), 32'h1);
    checkOutput("rerun_spikes", 32'(spikes_in), 32'h1234);
    checkOutput("rerun_ein", 32'(Ein_ext), 32'h5A);
    checkOutput("rerun_count1", 32'(count1), 32'h0);
    checkOutput("rerun_count2", 32'(count2), 32'h0);
    checkOutput("rerun_load_ready", 32'(load_ready), 32'h0);

    applyStimulus(1'b1, 16'hFFFF, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("busy_load_ready", 32'(load_ready), 32'h0);

    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("busy_start_phase", 32'(phase), 32'h1);
    checkOutput("busy_start_strobe", 32'(step_strobe), 32'h0);
    checkOutput("busy_start_spikes", 32'(spikes_in), 32'h0);

    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("busy_load_spikes", 32'(spikes_in), 32'h1234);
    checkOutput("busy_load_ein", 32'(Ein_ext), 32'h5A);

    for (int i = 4; i < 20; i++) applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_enter_c", 32'(phase), 32'h3);
    force dut.count1_q = 16'hFFFD;
    force dut.count2_q = 16'hFFFE;
    #1;
    release dut.count1_q;
    release dut.count2_q;

    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("sat_mid_count1", 32'(count1), 32'hFFFF);
    checkOutput("sat_mid_count2", 32'(count2), 32'hFFFF);
    for (int i = 22; i < 28; i++) applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("sat_done", 32'(done), 32'h1);
    checkOutput("sat_count1", 32'(count1), 32'hFFFF);
    checkOutput("sat_count2", 32'(count2), 32'hFFFF);

    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("run3_count1", 32'(count1), 32'h0);
    checkOutput("run3_count2", 32'(count2), 32'h0);
    checkOutput("run3_spikes", 32'(spikes_in), 32'h1234);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("midb_phase", 32'(phase), 32'h2);
    checkOutput("midb_spikes", 32'(spikes_in), 32'h1234);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("arst_status", 32'({busy, done, phase, step_strobe}), 32'h0);
    checkOutput("arst_ctrl", 32'(ctrlBus), 32'h0);
    checkOutput("arst_spikes", 32'(spikes_in), 32'h0);
    checkOutput("arst_ein", 32'(Ein_ext), 32'h0);
    checkOutput("arst_counts", 32'({count1, count2}), 32'h0);
    checkOutput("arst_load_ready", 32'(load_ready), 32'h1);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;

    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_phase", 32'(phase), 32'h1);
    checkOutput("post_rst_strobe", 32'(step_strobe), 32'h1);
    checkOutput("post_rst_spikes", 32'(spikes_in), 32'h0);
    checkOutput("post_rst_ein", 32'(Ein_ext), 32'h0);
    checkOutput("post_rst_ctrl", 32'(ctrlBus), 32'b1011011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
